// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Results are computed from the captured operands and written to HI/LO when the busy window ends.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       md_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               in_is_div, in_is_long;
  logic               commit;
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
  logic               div_ok;

  assign in_is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign in_is_long = in_is_div || (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_MADD) || (md_op == OP_MSUB);

  // Arithmetic on captured operands; only sampled on the commit cycle.
  always_comb begin
    a_sx       = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_sx       = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_s     = a_sx * b_sx;
    prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_ok     = (b_q != '0);
    // Magnitude divide keeps the -2^(W-1) / -1 case exact: quotient wraps back to -2^(W-1).
    a_mag      = a_q[WIDTH-1] ? -a_q : a_q;
    b_mag      = b_q[WIDTH-1] ? -b_q : b_q;
    b_mag_safe = div_ok ? b_mag : {{(WIDTH-1){1'b0}}, 1'b1};
    b_u_safe   = div_ok ? b_q   : {{(WIDTH-1){1'b0}}, 1'b1};
    quo_mag    = a_mag / b_mag_safe;
    rem_mag    = a_mag % b_mag_safe;
    quo_s      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_mag : quo_mag;
    rem_s      = a_q[WIDTH-1] ? -rem_mag : rem_mag;
    quo_u      = a_q / b_u_safe;
    rem_u      = a_q % b_u_safe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start && in_is_long) begin
          state_d = S_RUN;
          cnt_d   = in_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          a_d     = a;
          b_d     = b;
          op_d    = md_op;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    commit = busy && (cnt_q == '0);
    hi_d   = hi_q;
    lo_d   = lo_q;
    if ((state_q == S_IDLE) && start) begin
      if (md_op == OP_MTHI) hi_d = a;
      if (md_op == OP_MTLO) lo_d = a;
    end
    if (commit) begin
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        OP_DIV:   if (div_ok) begin hi_d = rem_s; lo_d = quo_s; end
        OP_DIVU:  if (div_ok) begin hi_d = rem_u; lo_d = quo_u; end
        default:  ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
